// File: rtl/fetch_pc_unit.sv
// Program-counter and fetch sequencer feeding a registered-read instruction
// memory. Selects the next fetch address (sequential, stall, branch, jr,
// jump), tracks the word the memory is presenting to decode, squashes
// wrong-path words, and traps misaligned redirect targets.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] fetch_pc,
    output logic        fetch_valid,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic        fetch_valid_reg, fetch_valid_next;
    logic        fetch_err_reg, fetch_err_next;

    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] jump_target;
    logic        misaligned;

    // Jump region comes from the jump instruction's own pc + 4, which is the
    // word decode currently holds (fetch_pc), not the speculative pc.
    assign jump_target = ((fetch_pc_reg + 32'd4) & 32'hF000_0000)
                       | {4'b0000, jump_index, 2'b00};
    assign redirect    = branch_taken | jr | jump;

    // Redirect target priority: branch (older instruction) over jr over jump.
    always_comb begin
        redirect_target = jump_target;
        if (branch_taken)
            redirect_target = branch_target;
        else if (jr)
            redirect_target = jr_target;
    end

    assign misaligned = redirect && (redirect_target[1:0] != 2'b00);

    // State and datapath registers; asynchronous reset returns to BOOT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_BOOT;
            pc_reg          <= RESET_PC;
            fetch_pc_reg    <= 32'h0000_0000;
            fetch_valid_reg <= 1'b0;
            fetch_err_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            fetch_pc_reg    <= fetch_pc_next;
            fetch_valid_reg <= fetch_valid_next;
            fetch_err_reg   <= fetch_err_next;
        end
    end

    // Next-state: BOOT lasts one cycle, a misaligned redirect traps forever.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_BOOT:  state_next = ST_RUN;
            ST_RUN:   if (misaligned) state_next = ST_ERROR;
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_BOOT;
        endcase
    end

    // Next pc and fetch-tracking values for the current state and inputs.
    always_comb begin
        pc_next          = pc_reg;
        fetch_pc_next    = fetch_pc_reg;
        fetch_valid_next = fetch_valid_reg;
        fetch_err_next   = fetch_err_reg;
        case (state_reg)
            ST_BOOT: begin
                fetch_valid_next = 1'b0;
            end
            ST_RUN: begin
                if (misaligned) begin
                    fetch_valid_next = 1'b0;
                    fetch_err_next   = 1'b1;
                end else if (redirect) begin
                    // Word read this cycle is wrong-path: track it but squash.
                    pc_next          = redirect_target;
                    fetch_pc_next    = pc_reg;
                    fetch_valid_next = 1'b0;
                end else if (!stall) begin
                    pc_next          = pc_reg + PC_STEP;
                    fetch_pc_next    = pc_reg;
                    fetch_valid_next = 1'b1;
                end
            end
            ST_ERROR: begin
                fetch_valid_next = 1'b0;
                fetch_err_next   = 1'b1;
            end
            default: begin
                fetch_valid_next = 1'b0;
            end
        endcase
    end

    assign pc          = pc_reg;
    assign pc_plus4    = pc_reg + PC_STEP;
    assign fetch_pc    = fetch_pc_reg;
    assign fetch_valid = fetch_valid_reg;
    assign fetch_err   = fetch_err_reg;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: hand-computed pc / fetch sequences for
// boot, stall, redirect priority, jump region, wrap, error trap and async reset.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jr;
    logic [31:0] jr_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        fetch_err;

    int n_checks;
    int n_fail;
    int n_step;

    fetch_pc_unit #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jr           (jr),
        .jr_target    (jr_target),
        .jump         (jump),
        .jump_index   (jump_index),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .fetch_pc     (fetch_pc),
        .fetch_valid  (fetch_valid),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One transaction = one rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n_step++;
        $display("step %0d: pc=%h pc_plus4=%h fetch_pc=%h valid=%0b err=%0b",
                 n_step, pc, pc_plus4, fetch_pc, fetch_valid, fetch_err);
    endtask

    task automatic expect_all(input string tag, input logic [31:0] e_pc,
                              input logic [31:0] e_fpc, input logic e_valid,
                              input logic e_err);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".fetch_pc"}, fetch_pc, e_fpc);
        check({tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, e_valid});
        check({tag, ".err"}, {31'd0, fetch_err}, {31'd0, e_err});
    endtask

    task automatic clear_inputs();
        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        jr = 1'b0; jr_target = 32'd0; jump = 1'b0; jump_index = 26'd0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_step = 0;
        clear_inputs();
        rst = 1'b0;
        #12;
        expect_all("reset", 32'h0, 32'h0, 1'b0, 1'b0);
        check("reset.pc_plus4", pc_plus4, 32'h4);

        // Boot and sequential fetch
        @(negedge clk);
        rst = 1'b1;
        step(); expect_all("boot", 32'h0, 32'h0, 1'b0, 1'b0);
        step(); expect_all("seq1", 32'h4, 32'h0, 1'b1, 1'b0);
        step(); expect_all("seq2", 32'h8, 32'h4, 1'b1, 1'b0);
        step(); expect_all("seq3", 32'hC, 32'h8, 1'b1, 1'b0);
        step(); expect_all("seq4", 32'h10, 32'hC, 1'b1, 1'b0);

        // Stall for three cycles at pc=0x10
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); expect_all("stall", 32'h10, 32'hC, 1'b1, 1'b0);
        end
        stall = 1'b0;
        step(); expect_all("unstall", 32'h14, 32'h10, 1'b1, 1'b0);
        step(); step(); step();
        expect_all("to20", 32'h20, 32'h1C, 1'b1, 1'b0);

        // Branch beats simultaneous jump
        branch_taken = 1'b1; branch_target = 32'h100;
        jump = 1'b1; jump_index = 26'h3FF;
        step(); expect_all("br_vs_jmp", 32'h100, 32'h20, 1'b0, 1'b0);
        clear_inputs();
        step(); expect_all("after_br", 32'h104, 32'h100, 1'b1, 1'b0);

        // Jump region taken from fetch_pc + 4
        branch_taken = 1'b1; branch_target = 32'h3000_0008;
        step(); expect_all("br_3000", 32'h3000_0008, 32'h104, 1'b0, 1'b0);
        clear_inputs();
        step(); expect_all("fpc_3000", 32'h3000_000C, 32'h3000_0008, 1'b1, 1'b0);
        jump = 1'b1; jump_index = 26'h40;
        step(); expect_all("jump", 32'h3000_0100, 32'h3000_000C, 1'b0, 1'b0);

        // Redirect overrides stall
        clear_inputs();
        stall = 1'b1; jr = 1'b1; jr_target = 32'h40;
        step(); expect_all("jr_stall", 32'h40, 32'h3000_0100, 1'b0, 1'b0);
        clear_inputs();
        step(); expect_all("after_jr", 32'h44, 32'h40, 1'b1, 1'b0);

        // Wrap at the top of the address space
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8;
        step(); check("wrap0.pc", pc, 32'hFFFF_FFF8);
        check("wrap0.pc_plus4", pc_plus4, 32'hFFFF_FFFC);
        clear_inputs();
        step(); expect_all("wrap1", 32'hFFFF_FFFC, 32'hFFFF_FFF8, 1'b1, 1'b0);
        check("wrap1.pc_plus4", pc_plus4, 32'h0);
        step(); expect_all("wrap2", 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0);
        step(); expect_all("pre_err", 32'h4, 32'h0, 1'b1, 1'b0);

        // Misaligned jr target traps
        jr = 1'b1; jr_target = 32'h42;
        step(); expect_all("err", 32'h4, 32'h0, 1'b0, 1'b1);
        clear_inputs();
        branch_taken = 1'b1; branch_target = 32'h200;
        step(); expect_all("err_hold1", 32'h4, 32'h0, 1'b0, 1'b1);
        clear_inputs();
        step(); expect_all("err_hold2", 32'h4, 32'h0, 1'b0, 1'b1);

        // Reset exits the error state
        #2 rst = 1'b0;
        #1 expect_all("err_rst", 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        // Redirect during BOOT is ignored
        branch_taken = 1'b1; branch_target = 32'h80;
        step(); expect_all("boot2", 32'h0, 32'h0, 1'b0, 1'b0);
        clear_inputs();
        step(); expect_all("run2", 32'h4, 32'h0, 1'b1, 1'b0);
        step(); step();
        expect_all("run3", 32'hC, 32'h8, 1'b1, 1'b0);

        // Async reset mid-cycle, with a redirect pending
        jr = 1'b1; jr_target = 32'h500;
        @(posedge clk);
        #3 rst = 1'b0;
        #1 expect_all("async_rst", 32'h0, 32'h0, 1'b0, 1'b0);
        check("async_rst.pc_plus4", pc_plus4, 32'h4);
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        step(); expect_all("boot3", 32'h0, 32'h0, 1'b0, 1'b0);
        step(); expect_all("run4", 32'h4, 32'h0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Program-counter and fetch-sequencing stage that sits directly upstream of the instruction memory. Drives the memory's pc input and applies sequential increment, stall, and redirects (branch, jump, jump-register). Tracks the one-cycle registered-read latency of the memory so that fetch_pc/fetch_valid are aligned with the instruction word the memory presents to decode. Traps misaligned redirect targets into a sticky error state.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
PC_STEP, 4, byte increment per sequential fetch.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
stall  input  1  hazard stall from decode; freezes pc and fetch tracking.
branch_taken  input  1  EX-stage branch resolved taken.
branch_target  input  32  branch destination byte address.
jr  input  1  jump-register issued from decode.
jr_target  input  32  register-sourced destination.
jump  input  1  J/JAL issued from decode.
jump_index  input  26  instr[25:0] of the jump.
pc  output  32  fetch address to the instruction memory.
pc_plus4  output  32  pc + PC_STEP (combinational from pc).
fetch_pc  output  32  address of the word the memory currently outputs.
fetch_valid  output  1  memory output word is a real, non-squashed instruction.
fetch_err  output  1  sticky misaligned-target error.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, fetch_pc=0, fetch_valid=0, fetch_err=0, state=BOOT. pc_plus4=RESET_PC+4.
- FSM states: BOOT, RUN, ERROR.
- BOOT: lasts exactly one clock after rst deasserts. pc holds RESET_PC, fetch_valid stays 0, redirects and stall are ignored. Next state is RUN.
- RUN: at each rising edge, the next pc is selected by priority:
  1. branch_taken: branch_target.
  2. jr: jr_target.
  3. jump: {fetch_pc_plus4[31:28], jump_index, 2'b00}, where fetch_pc_plus4 = fetch_pc + 4.
  4. stall: hold pc.
  5. Otherwise: pc + PC_STEP, wrapping modulo 2^32 (32'hFFFF_FFFC goes to 0).
- Redirects override stall. Branch has priority because it comes from the older instruction.
- Fetch tracking (memory read is registered: the word for the pc present in cycle k appears after edge k+1):
  - At each edge in RUN: fetch_pc <= pc; fetch_valid <= ~redirect, where redirect = branch_taken | jr | jump. The word fetched in a redirect cycle is wrong-path and is squashed.
  - With stall and no redirect: fetch_pc and fetch_valid hold. The memory re-reads the same address, so the output stays consistent.
- Misalignment: if the selected redirect target has [1:0] != 2'b00, the next state is ERROR. pc holds its current value, fetch_valid <= 0, fetch_err <= 1.
- ERROR: pc, fetch_pc, fetch_valid=0 and fetch_err=1 are frozen, and all inputs are ignored. Only rst exits this state.
- Reset mid-operation: the asynchronous assert immediately forces all outputs to their reset values. Any redirect pending in that cycle is lost.
- All outputs are registered except pc_plus4. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset release, no stall/redirect → one BOOT cycle with pc=0. pc then goes 0,4,8,C. fetch_pc lags pc by one edge and matches it; fetch_valid first rises two edges after rst deasserts.
- stall=1 for 3 cycles at pc=0x10 → pc, fetch_pc and fetch_valid unchanged for 3 cycles; pc=0x14 on the edge after stall drops.
- branch_taken=1, target=0x100, and jump=1 in the same cycle, at pc=0x20 → pc=0x100; fetch_valid=0 for that word; next fetch_pc=0x100 with valid=1.
- jump with fetch_pc=0x3000_0008, jump_index=26'h40 → pc=0x3000_0100. stall=1 with jr=1, jr_target=0x40 → pc=0x40 (redirect beats stall).
- jr_target=0x42 → fetch_err=1, pc frozen, fetch_valid=0, later inputs ignored; asserting rst clears to pc=RESET_PC, fetch_err=0.
- Sequential run from pc=0xFFFF_FFF8 → 0xFFFF_FFFC then 0x0000_0000. Async rst pulse mid-cycle → outputs reset before the next clock edge.
